// File: rtl/multi_port_mem_ctrler_pkg.sv
// multi_port_mem_ctrler_pkg: shared size/state encodings, IO space constant and datapath widths
package multi_port_mem_ctrler_pkg;
  localparam int ADDR_TYPE_W = 32;
  localparam int DATA_TYPE_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [1:0] IO_SPACE = 2'b11;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  // Illegal size 3 falls through to a word access.
  function automatic logic [2:0] nbytes(input logic [1:0] s);
    return s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/multi_port_mem_ctrler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts at pointer
//   req     : per-port request
//   pointer : highest-priority port index
//   grant   : one-hot grant (zero when no request)
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        pointer,
  output logic [NUM_PORTS-1:0] grant
);
  logic [PW-1:0] idx;
  // Walk from lowest to highest priority so the last hit (closest to pointer) wins.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PW'((int'(pointer) + i) % NUM_PORTS);
      if (req[idx]) grant = NUM_PORTS'(1) << idx;
    end
  end
endmodule

// File: rtl/multi_port_mem_ctrler.sv
// multi_port_mem_ctrler: arbitrates byte/half/word requests from several ports onto a byte-wide RAM
//   clk, rst, rdy             : clock, sync active-high reset, global enable
//   *_from_port / *_to_port   : per-port request bundle and shared completion/read data
//   *_ram, io_buffer_full     : byte-wide RAM interface and UART backpressure
module multi_port_mem_ctrler
  import multi_port_mem_ctrler_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WIDTH = ADDR_TYPE_W,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rdy,
  input  logic [NUM_PORTS-1:0]              valid_from_port,
  input  logic [NUM_PORTS-1:0]              rw_flag_from_port,
  input  logic [2*NUM_PORTS-1:0]            size_from_port,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]   addr_from_port,
  input  logic [DATA_TYPE_W*NUM_PORTS-1:0]  data_from_port,
  output logic [NUM_PORTS-1:0]              ready_to_port,
  output logic [DATA_TYPE_W-1:0]            data_to_port,
  input  logic [BYTE_W-1:0]                 data_from_ram,
  input  logic                              io_buffer_full,
  output logic                              rw_select_to_ram,
  output logic [ADDR_WIDTH-1:0]             addr_to_ram,
  output logic [BYTE_W-1:0]                 data_to_ram
);
  state_e state_q;
  logic [PW-1:0] ptr_q, gidx;
  logic [NUM_PORTS-1:0] grant, sel_q, ready_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, g_addr;
  logic [DATA_TYPE_W-1:0] wdata_q, rbuf_q, rbuf_n, data_q, g_data;
  logic [BYTE_W-1:0] wbyte_q;
  logic [2:0] cnt_q, nb_q;
  logic [1:0] g_size;
  logic g_rw, stall;
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (.req(valid_from_port), .pointer(ptr_q), .grant(grant));
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (grant[i]) gidx = PW'(i);
  end
  assign g_size = size_from_port[gidx*2 +: 2];
  assign g_addr = addr_from_port[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_data = data_from_port[gidx*DATA_TYPE_W +: DATA_TYPE_W];
  assign g_rw = rw_flag_from_port[gidx];
  // RAM data arriving now answers the address issued one cycle earlier (byte cnt-1).
  always_comb begin
    rbuf_n = rbuf_q;
    if (cnt_q != 3'd0) rbuf_n[{cnt_q - 3'd1, 3'b000} +: BYTE_W] = data_from_ram;
  end
  assign stall = addr_q[17:16] == IO_SPACE && io_buffer_full;
  assign rw_select_to_ram = state_q == WRITE && rdy && !stall;
  assign ready_to_port = ready_q;
  assign data_to_port = data_q;
  assign addr_to_ram = addr_q;
  assign data_to_ram = wbyte_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      ready_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      base_q <= '0;
      wdata_q <= '0;
      wbyte_q <= '0;
      rbuf_q <= '0;
      cnt_q <= '0;
      nb_q <= '0;
    end else if (rdy) begin
      ready_q <= '0;
      case (state_q)
        IDLE: if (|valid_from_port) begin
          sel_q <= grant;
          ptr_q <= gidx == PW'(NUM_PORTS - 1) ? '0 : gidx + PW'(1);
          base_q <= g_addr;
          addr_q <= g_addr;
          wdata_q <= g_data;
          wbyte_q <= g_rw ? g_data[7:0] : '0;
          nb_q <= nbytes(g_size);
          cnt_q <= '0;
          rbuf_q <= '0;
          state_q <= g_rw ? WRITE : READ;
        end
        READ: begin
          cnt_q <= cnt_q + 3'd1;
          rbuf_q <= rbuf_n;
          addr_q <= cnt_q + 3'd1 < nb_q ? base_q + ADDR_WIDTH'(cnt_q + 3'd1) : '0;
          if (cnt_q == nb_q) begin
            state_q <= DONE;
            ready_q <= sel_q;
            data_q <= rbuf_n;
          end
        end
        WRITE: if (!stall) begin
          if (cnt_q == nb_q - 3'd1) begin
            state_q <= DONE;
            ready_q <= sel_q;
            addr_q <= '0;
            wbyte_q <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            addr_q <= base_q + ADDR_WIDTH'(cnt_q + 3'd1);
            wbyte_q <= wdata_q[15:8];
            wdata_q <= wdata_q >> 8;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_port_mem_ctrler.sv
// tb_multi_port_mem_ctrler: directed scoreboard bench for multi_port_mem_ctrler
module tb_multi_port_mem_ctrler;
  logic clk = 0, rst = 1, rdy = 1, io_buffer_full = 0;
  logic [1:0] valid_from_port = '0, rw_flag_from_port = '0, ready_to_port;
  logic [3:0] size_from_port = '0;
  logic [63:0] addr_from_port = '0, data_from_port = '0;
  logic [31:0] data_to_port, addr_to_ram;
  logic [7:0] data_from_ram = '0, data_to_ram;
  logic rw_select_to_ram;
  logic [7:0] mem [0:1023];
  int cyc = 0, checks = 0, errors = 0, lat;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [1:0] mask; logic is_rd; logic [31:0] d;} rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  multi_port_mem_ctrler #(.NUM_PORTS(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_from_port(valid_from_port), .rw_flag_from_port(rw_flag_from_port),
    .size_from_port(size_from_port), .addr_from_port(addr_from_port),
    .data_from_port(data_from_port), .ready_to_port(ready_to_port),
    .data_to_port(data_to_port), .data_from_ram(data_from_ram),
    .io_buffer_full(io_buffer_full), .rw_select_to_ram(rw_select_to_ram),
    .addr_to_ram(addr_to_ram), .data_to_ram(data_to_ram)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous RAM sharing the global enable: one-cycle read latency.
  always @(posedge clk) if (rdy) data_from_ram <= mem[addr_to_ram[9:0]];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every RAM write and every ready pulse must match the queued expectation.
  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (rw_select_to_ram === 1'b1) begin
      checks++;
      assert (exp_wr.size() != 0) else begin
        errors++;
        $error("FAIL wr_extra got addr=%h data=%h expected no write", addr_to_ram, data_to_ram);
      end
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        checks++;
        assert ({addr_to_ram, data_to_ram} === {w.a, w.d}) else begin
          errors++;
          $error("FAIL wr_byte got addr=%h data=%h expected addr=%h data=%h", addr_to_ram, data_to_ram, w.a, w.d);
        end
      end
    end
    if (|ready_to_port) begin
      checks++;
      assert (exp_rd.size() != 0) else begin
        errors++;
        $error("FAIL ready_extra got ready=%b expected none", ready_to_port);
      end
      if (exp_rd.size() != 0) begin
        r = exp_rd.pop_front();
        checks++;
        assert (ready_to_port === r.mask && (!r.is_rd || data_to_port === r.d)) else begin
          errors++;
          $error("FAIL completion got ready=%b data=%h expected ready=%b data=%h", ready_to_port, data_to_port, r.mask, r.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input int p, input logic rw, input int n, input logic [31:0] a);
    rd_t e;
    e.mask = 2'b01 << p;
    e.is_rd = !rw;
    e.d = '0;
    for (int k = 0; k < n; k++) e.d[8*k +: 8] = mem[(a + 32'(k)) & 32'h3ff];
    exp_rd.push_back(e);
  endtask

  // Issue one request from an idle cycle; lat = cycles from grant cycle to ready cycle (-1 on timeout).
  task automatic req(input int p, input logic rw, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    int n, t0;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    @(negedge clk);
    #1;
    if (rw) for (int k = 0; k < n; k++) exp_wr.push_back('{a + 32'(k), d[8*k +: 8]});
    push_rd(p, rw, n, a);
    rw_flag_from_port[p] = rw;
    size_from_port[2*p +: 2] = sz;
    addr_from_port[32*p +: 32] = a;
    data_from_port[32*p +: 32] = d;
    valid_from_port[p] = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_to_port[p]) begin
        lat = cyc - t0;
        break;
      end
    end
    #1 valid_from_port[p] = 1'b0;
  endtask

  initial begin
    logic [1:0] rr_exp;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7);
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
    mem[16] = 8'hA5; mem[32] = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_to_port, 2'b00);
    chk("rst_data_to_port", data_to_port, 32'h0);
    chk("rst_rw", rw_select_to_ram, 1'b0);
    chk("rst_addr", addr_to_ram, 32'h0);
    chk("rst_wdata", data_to_ram, 8'h0);
    #1 rst = 0;
    // Word read on port 1
    req(1, 1'b0, 2'd2, 32'h100, 32'h0, lat);
    chk("word_read_latency", lat, 6);
    chk("word_read_data", data_to_port, 32'h44332211);
    // Unaligned half write on port 0
    req(0, 1'b1, 2'd1, 32'h203, 32'h0000BEEF, lat);
    chk("half_write_latency", lat, 3);
    chk("read_data_retained", data_to_port, 32'h44332211);
    @(negedge clk);
    chk("idle_addr_zero", addr_to_ram, 32'h0);
    // IO-space byte write held off by a full UART buffer for five cycles
    io_buffer_full = 1'b1;
    fork
      req(0, 1'b1, 2'd0, 32'h30000, 32'h00000041, lat);
      begin
        @(negedge clk);
        #1;
        repeat (6) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join
    chk("io_write_latency", lat, 7);
    // Byte read zero-extends
    req(0, 1'b0, 2'd0, 32'h10, 32'h0, lat);
    chk("byte_read_latency", lat, 3);
    chk("byte_read_zext", data_to_port, 32'h000000A5);
    // Word read frozen by rdy for three cycles
    fork
      req(0, 1'b0, 2'd2, 32'h100, 32'h0, lat);
      begin
        @(negedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    chk("rdy_stall_latency", lat, 9);
    chk("rdy_stall_data", data_to_port, 32'h44332211);
    // Round robin with both ports continuously requesting, pointer reset to 0
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    rw_flag_from_port = 2'b00;
    size_from_port = 4'b0000;
    addr_from_port = {32'h20, 32'h10};
    for (int k = 0; k < 4; k++) push_rd(k % 2, 1'b0, 1, k % 2 ? 32'h20 : 32'h10);
    valid_from_port = 2'b11;
    for (int k = 0; k < 4; k++) begin
      rr_exp = k % 2 ? 2'b10 : 2'b01;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (|ready_to_port) break;
      end
      chk($sformatf("rr_grant_%0d", k), ready_to_port, rr_exp);
    end
    #1 valid_from_port = 2'b00;
    // Reset in the middle of a word write: two bytes go out, then everything clears with no ready
    repeat (2) @(negedge clk);
    #1;
    exp_wr.push_back('{32'h300, 8'h0D});
    exp_wr.push_back('{32'h301, 8'hF0});
    rw_flag_from_port[1] = 1'b1;
    size_from_port[3:2] = 2'd2;
    addr_from_port[63:32] = 32'h300;
    data_from_port[63:32] = 32'hCAFEF00D;
    valid_from_port[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_ready", ready_to_port, 2'b00);
    chk("midrst_data_to_port", data_to_port, 32'h0);
    chk("midrst_rw", rw_select_to_ram, 1'b0);
    chk("midrst_addr", addr_to_ram, 32'h0);
    chk("midrst_wdata", data_to_ram, 8'h0);
    #1;
    valid_from_port = 2'b00;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", ready_to_port, 2'b00);
    end
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_port_mem_ctrler.md
MULTI_PORT_MEM_CTRLER -- requirements
Module: multi_port_mem_ctrler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requestor ports (port 0 = icache, port 1 = dcache, extra ports for future units).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rdy  in  1  global enable; all state frozen when low.
REQ-007 valid_from_port  in  NUM_PORTS  per-port request valid.
REQ-008 rw_flag_from_port  in  NUM_PORTS  per-port 1=write, 0=read.
REQ-009 size_from_port  in  2*NUM_PORTS  per-port size: 0=byte, 1=half, 2=word (3 illegal, treated as word).
REQ-010 addr_from_port  in  ADDR_WIDTH*NUM_PORTS  per-port byte address, port i at slice i.
REQ-011 data_from_port  in  32*NUM_PORTS  per-port write data, little-endian.
REQ-012 ready_to_port  out  NUM_PORTS  one-cycle completion pulse, at most one bit set.
REQ-013 data_to_port  out  32  read data, shared, valid only with ready bit, zero-extended.
REQ-014 data_from_ram  in  8  RAM read byte.
REQ-015 io_buffer_full  in  1  UART buffer full.
REQ-016 rw_select_to_ram  out  1  1=write.
REQ-017 addr_to_ram  out  ADDR_WIDTH  RAM byte address.
REQ-018 data_to_ram  out  8  RAM write byte.

Function
REQ-019 States IDLE, READ, WRITE, DONE; IDLE->READ/WRITE on grant, READ/WRITE->DONE after last byte, DONE->IDLE unconditionally.
REQ-020 Arbitration in IDLE: round-robin among asserted valids starting at pointer; pointer <= granted+1 mod NUM_PORTS on grant; pointer resets to 0.
REQ-021 On grant, addr/data/size/rw of granted port latched; requestor holds inputs stable until ready and drops valid at the edge ending its ready cycle.
REQ-022 Byte count N = 1/2/4; byte k uses address latched_addr+k, no alignment required.
REQ-023 Read: addresses issued in consecutive cycles T1..TN (grant sampled T0); byte k captured from data_from_ram in cycle after its address; ready in cycle T0+N+2.
REQ-024 Write: byte k driven with rw_select_to_ram=1 in cycle T1+k; ready in cycle T0+N+1.
REQ-025 Write to IO space (addr[17:16]==2'b11) while io_buffer_full=1 SHALL hold the current byte with rw_select_to_ram=0 until not full, then write it.
REQ-026 Outside active write cycles rw_select_to_ram=0; in IDLE/DONE addr_to_ram=0, data_to_ram=0.
REQ-027 No new grant in DONE; first possible new grant is the IDLE cycle after DONE.
REQ-028 rdy low: state, counters, outputs held; rw_select_to_ram forced 0; captured bytes not overwritten; sequence resumes at the same byte.
REQ-029 data_to_port retains last read value until the next read completes.

Reset
REQ-030 rst high SHALL, at the next edge, force IDLE, pointer=0, ready_to_port=0, data_to_port=0, rw_select_to_ram=0, addr_to_ram=0, data_to_ram=0; in-flight access abandoned with no ready issued.
REQ-031 rst has priority over rdy.

Structure
REQ-032 Size encodings, state encodings, IO address constant and ADDR_TYPE/DATA_TYPE widths SHALL live in the shared defines header.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arbiter (parameter NUM_PORTS; inputs req, pointer; output one-hot grant).

Verification
REQ-034 Port1 word read at 0x100, RAM bytes 11,22,33,44 -> ready_to_port=2'b10 at T0+6, data_to_port=0x44332211.
REQ-035 Port0 half write 0xBEEF to 0x203 -> cycles T1,T2 write 0xEF@0x203, 0xBE@0x204; ready at T0+3.
REQ-036 Both ports valid continuously, pointer=0 -> grants alternate 0,1,0,1; no port starved.
REQ-037 Byte write 0x41 to 0x30000 with io_buffer_full high 5 cycles -> no write for 5 cycles, then one write, ready next cycle.
REQ-038 rdy low 3 cycles mid word read -> resumed result identical to uninterrupted read; rst mid write -> all outputs 0, no ready.
